// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: word-organised memory with byte lanes, a configurable
// number of wait states per OKAY transfer, and a two-cycle ERROR response for
// misaligned, oversized or out-of-range transfers.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no stall; a data phase (if any) completes this cycle
// ST_WAIT  | legal transfer accepted, inserting wait states
// ST_ERR1  | first ERROR cycle (HREADYOUT low)
// ST_ERR2  | second ERROR cycle (HREADYOUT high), data phase ends
module ahb_lite_sram_slave #(
  parameter int MEM_WORDS   = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic        HMASTLOCK,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA
);

  localparam int         AW        = $clog2(MEM_WORDS);
  localparam bit         ZERO_WAIT = (WAIT_STATES == 0);
  localparam logic [1:0] WAIT_LOAD = 2'(WAIT_STATES - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  state_t          state;
  logic [1:0]      wait_cnt;
  logic            dp_wr;
  logic            dp_rd;
  logic [AW-1:0]   dp_idx;
  logic [3:0]      dp_strb;

  logic [31:0]     mem [MEM_WORDS];

  logic            accept;
  logic            addr_legal;
  logic [3:0]      addr_strb;
  logic            wr_en;
  logic [31:0]     wr_word;
  logic [AW-1:0]   rd_idx;
  logic [31:0]     rd_word;

  // Sideband signals that carry no meaning for a simple memory.
  logic unused_ok;
  assign unused_ok = &{1'b0, HTRANS[0], HBURST, HPROT, HMASTLOCK};

  // Address-phase decode: acceptance, legality and byte-lane mask.
  always_comb begin
    accept = HSEL & HREADY & HTRANS[1];
    case (HSIZE)
      3'd0:    addr_legal = 1'b1;
      3'd1:    addr_legal = ~HADDR[0];
      3'd2:    addr_legal = (HADDR[1:0] == 2'b00);
      default: addr_legal = 1'b0;
    endcase
    if (HADDR[31:AW+2] != '0) addr_legal = 1'b0;
    case (HSIZE)
      3'd0:    addr_strb = 4'b0001 << HADDR[1:0];
      3'd1:    addr_strb = HADDR[1] ? 4'b1100 : 4'b0011;
      default: addr_strb = 4'b1111;
    endcase
  end

  // Write merge, plus a bypass so a read loading its data at the same edge a
  // write completes to the same word sees the new value.
  always_comb begin
    wr_en   = HRESETn & dp_wr & HREADYOUT;
    wr_word = mem[dp_idx];
    for (int i = 0; i < 4; i++) begin
      if (dp_strb[i]) wr_word[8*i +: 8] = HWDATA[8*i +: 8];
    end
    rd_idx  = (state == ST_WAIT) ? dp_idx : HADDR[AW+1:2];
    rd_word = (wr_en && (rd_idx == dp_idx)) ? wr_word : mem[rd_idx];
  end

  // Memory array: written only at the edge ending a legal write data phase.
  always_ff @(posedge HCLK) begin
    if (wr_en) mem[dp_idx] <= wr_word;
  end

  // Transfer sequencing with registered bus outputs.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state     <= ST_IDLE;
      wait_cnt  <= 2'd0;
      dp_wr     <= 1'b0;
      dp_rd     <= 1'b0;
      dp_idx    <= '0;
      dp_strb   <= 4'b0000;
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= 32'h0;
    end else begin
      case (state)
        ST_WAIT: begin
          if (wait_cnt == 2'd0) begin
            state     <= ST_IDLE;
            HREADYOUT <= 1'b1;
            HRDATA    <= dp_rd ? rd_word : 32'h0;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        ST_ERR1: begin
          state     <= ST_ERR2;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b1;
        end
        default: begin
          // Any data phase in progress ends at this edge.
          state     <= ST_IDLE;
          dp_wr     <= 1'b0;
          dp_rd     <= 1'b0;
          HREADYOUT <= 1'b1;
          HRESP     <= 1'b0;
          HRDATA    <= 32'h0;
          if (accept) begin
            if (!addr_legal) begin
              state     <= ST_ERR1;
              HREADYOUT <= 1'b0;
              HRESP     <= 1'b1;
            end else begin
              dp_wr   <= HWRITE;
              dp_rd   <= ~HWRITE;
              dp_idx  <= HADDR[AW+1:2];
              dp_strb <= addr_strb;
              if (ZERO_WAIT) begin
                HRDATA <= HWRITE ? 32'h0 : rd_word;
              end else begin
                state     <= ST_WAIT;
                wait_cnt  <= WAIT_LOAD;
                HREADYOUT <= 1'b0;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: doc/ahb_lite_sram_slave.md
AHB_LITE_SRAM_SLAVE -- requirements
Module: ahb_lite_sram_slave

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 256, memory depth in 32-bit words (power of two, 16..4096).
REQ-002 SHALL have parameter WAIT_STATES, default 1, HREADYOUT-low cycles inserted per OKAY transfer (0..3).
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 HCLK  input  1  rising-edge clock for all state.
REQ-005 HRESETn  input  1  synchronous active-low reset.
REQ-006 HSEL  input  1  slave select from decoder.
REQ-007 HADDR  input  32  byte address, address phase.
REQ-008 HWRITE  input  1  1 = write, 0 = read.
REQ-009 HSIZE  input  3  transfer size (0 byte, 1 halfword, 2 word).
REQ-010 HTRANS  input  2  IDLE 00, BUSY 01, NONSEQ 10, SEQ 11.
REQ-011 HBURST  input  3, HPROT  input  4, HMASTLOCK  input  1: accepted, ignored.
REQ-012 HREADY  input  1  bus-level ready; high = previous data phase ending.
REQ-013 HWDATA  input  32  write data, data phase.
REQ-014 HREADYOUT  output  1  slave ready.
REQ-015 HRESP  output  1  0 OKAY, 1 ERROR.
REQ-016 HRDATA  output  32  read data.

Function
REQ-017 Transfer SHALL be accepted at a rising edge where HSEL & HREADY & HTRANS[1]; HADDR, HWRITE, HSIZE registered at that edge.
REQ-018 IDLE/BUSY, or HSEL low, with HREADY high SHALL produce a zero-wait OKAY data phase with no memory access.
REQ-019 FSM states: ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2; a wait-state counter (2 bits) SHALL count down in ST_WAIT.
REQ-020 Accepted legal transfer: WAIT_STATES=0 -> data phase completes in one cycle (HREADYOUT=1); else ST_WAIT for WAIT_STATES cycles with HREADYOUT=0, HRESP=0, then one cycle HREADYOUT=1.
REQ-021 Illegal transfer SHALL be: HSIZE>2, halfword with HADDR[0]=1, word with HADDR[1:0]!=0, or HADDR >= 4*MEM_WORDS.
REQ-022 Illegal transfer: ST_ERR1 (HREADYOUT=0, HRESP=1) then ST_ERR2 (HREADYOUT=1, HRESP=1), no wait states, no memory write, HRDATA=0.
REQ-023 Write SHALL update memory at the edge ending the data phase (HREADYOUT=1), using HWDATA sampled there; lanes little-endian: byte -> lane HADDR[1:0]; halfword -> lanes {HADDR[1],0} and {HADDR[1],1}; word -> all four; other lanes unchanged.
REQ-024 Read SHALL drive the full addressed word on HRDATA during the data-phase cycle with HREADYOUT=1; HRDATA=0 in all other cycles.
REQ-025 Read data SHALL reflect any write completed at or before the edge that started that read's final data cycle (back-to-back write then read of same word returns new data).
REQ-026 A new address phase SHALL be accepted in the same cycle the prior data phase completes (pipelined back-to-back, no bubble).
REQ-027 Address phases presented while HREADY=0 SHALL be ignored.
REQ-028 HREADYOUT=1 and HRESP=0 SHALL hold whenever no data phase is pending.

Reset
REQ-029 HRESETn low at a rising edge SHALL force: state ST_IDLE, counter 0, HREADYOUT=1, HRESP=0, HRDATA=0, pending transfer discarded without memory write.
REQ-030 Reset asserted mid-wait or mid-error SHALL abort the transfer; memory contents SHALL NOT be reset.

Verification
REQ-031 WAIT_STATES=1: NONSEQ word write 0x10 data 0xDEADBEEF, then read 0x10 -> one HREADYOUT-low cycle each, HRDATA=0xDEADBEEF, HRESP=0.
REQ-032 Byte write 0xAA to 0x13 over word 0x11223344 at 0x10 -> read 0x10 returns 0xAA223344.
REQ-033 Word read at 0x12 (misaligned) -> HREADYOUT 0 then 1 with HRESP=1 both cycles; memory unchanged.
REQ-034 Read HADDR=0x400 with MEM_WORDS=256 -> two-cycle ERROR; following legal read completes OKAY.
REQ-035 WAIT_STATES=0: INCR4 writes 0x0,0x4,0x8,0xC back-to-back including one BUSY -> HREADYOUT constantly 1, four words stored, BUSY causes no write.
REQ-036 HRESETn low during ST_WAIT of a write -> next cycle HREADYOUT=1, HRESP=0, target word keeps old value.
